// File: rtl/conv_pkg.sv
// Shared defaults and types for the rate-1/2 convolutional encoder framer.
package conv_pkg;

  localparam int unsigned        K_DEF          = 4;
  localparam logic [K_DEF-1:0]   G0_DEF         = 4'b1111;
  localparam logic [K_DEF-1:0]   G1_DEF         = 4'b1101;
  localparam int unsigned        MAX_LEN_DEF    = 1024;
  localparam int unsigned        GAP_CYCLES_DEF = 4;

  // Encoded symbol {c1,c0}
  typedef logic [1:0] sym_t;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    TAIL,
    GAP
  } state_t;

endpackage

// File: rtl/conv_enc_core.sv
// Shift register plus generator parity; sym is combinational from in_bit and sr.
module conv_enc_core
  import conv_pkg::*;
#(
  parameter int unsigned  K  = K_DEF,
  parameter logic [K-1:0] G0 = G0_DEF,
  parameter logic [K-1:0] G1 = G1_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic in_bit,
  input  logic load,
  input  logic clr,
  output sym_t sym
);

  localparam int unsigned SW = K - 1;

  logic [SW-1:0] sr;
  logic [K-1:0]  w;

  // Current bit sits in the top tap, sr[SW-1] is the most recent previous bit
  assign w   = {in_bit, sr};
  assign sym = {^(w & G1), ^(w & G0)};

  // Shift the new bit in at the top; clr forces the trellis back to state zero
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      sr <= '0;
    end else if (load) begin
      sr <= SW'({in_bit, sr} >> 1);
    end
  end

endmodule

// File: rtl/conv_encoder_framer.sv
// Frames a serial bit stream into terminated convolutional-code symbol bursts
// separated by idle gaps.
module conv_encoder_framer
  import conv_pkg::*;
#(
  parameter int unsigned  K          = K_DEF,
  parameter logic [K-1:0] G0         = G0_DEF,
  parameter logic [K-1:0] G1         = G1_DEF,
  parameter int unsigned  MAX_LEN    = MAX_LEN_DEF,
  parameter int unsigned  GAP_CYCLES = GAP_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       s_valid,
  input  logic       s_data,
  input  logic       s_last,
  output logic       s_ready,
  output logic       m_valid,
  output logic [1:0] m_data,
  output logic       m_last,
  input  logic       m_ready,
  output logic       len_err
);

  localparam int unsigned CW = $clog2(MAX_LEN + 1);
  localparam int unsigned TW = (K > 2) ? $clog2(K - 1) : 1;
  localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  state_t        state;
  logic [CW-1:0] bit_cnt;
  logic [CW-1:0] bit_cnt_nxt;
  logic [TW-1:0] tail_cnt;
  logic [GW-1:0] gap_cnt;
  logic          adv;
  logic          accept;
  logic          tail_step;
  logic          tail_last;
  logic          enc_load;
  logic          enc_in;
  logic          enc_clr;
  sym_t          sym;

  assign adv         = !m_valid || m_ready;
  assign s_ready     = adv && ((state == IDLE) || (state == DATA));
  assign accept      = s_valid && s_ready;
  assign tail_step   = adv && (state == TAIL);
  assign tail_last   = (tail_cnt == TW'(K - 2));
  assign enc_load    = accept || tail_step;
  assign enc_in      = accept ? s_data : 1'b0;
  assign enc_clr     = (state == GAP);
  assign bit_cnt_nxt = (state == IDLE) ? CW'(1) : bit_cnt + CW'(1);

  conv_enc_core #(
    .K  (K),
    .G0 (G0),
    .G1 (G1)
  ) u_core (
    .clk    (clk),
    .rst    (rst),
    .in_bit (enc_in),
    .load   (enc_load),
    .clr    (enc_clr),
    .sym    (sym)
  );

  // Framer FSM, frame counters and the single output register stage
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      tail_cnt <= '0;
      gap_cnt  <= '0;
      m_valid  <= 1'b0;
      m_data   <= '0;
      m_last   <= 1'b0;
      len_err  <= 1'b0;
    end else begin
      len_err <= 1'b0;

      if (adv) begin
        m_valid <= enc_load;
        m_last  <= tail_step && tail_last;
        if (enc_load) begin
          m_data <= sym;
        end
      end

      case (state)
        IDLE, DATA: begin
          if (accept) begin
            bit_cnt <= bit_cnt_nxt;
            if (s_last || (bit_cnt_nxt == CW'(MAX_LEN))) begin
              state    <= TAIL;
              tail_cnt <= '0;
              len_err  <= !s_last;
            end else begin
              state <= DATA;
            end
          end
        end
        TAIL: begin
          if (adv) begin
            if (tail_last) begin
              state   <= GAP;
              gap_cnt <= '0;
            end else begin
              tail_cnt <= tail_cnt + TW'(1);
            end
          end
        end
        GAP: begin
          // Gap counting starts once the final tail symbol has left the output stage
          if (m_valid) begin
            if (m_ready && (GAP_CYCLES == 0)) begin
              state   <= IDLE;
              bit_cnt <= '0;
            end
          end else if (gap_cnt == GW'(GAP_CYCLES - 1)) begin
            state   <= IDLE;
            bit_cnt <= '0;
          end else begin
            gap_cnt <= gap_cnt + GW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_encoder_framer.sv
// Randomized bench for conv_encoder_framer with a frame-level reference model.
module tb_conv_encoder_framer;

  localparam int unsigned K          = 4;
  localparam logic [3:0]  G0         = 4'b1111;
  localparam logic [3:0]  G1         = 4'b1101;
  localparam int unsigned MAX_LEN    = 8;
  localparam int unsigned GAP_CYCLES = 4;

  typedef enum int {PH_OPEN, PH_CLOSING, PH_GAP} ph_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       s_valid = 1'b0;
  logic       s_data = 1'b0;
  logic       s_last = 1'b0;
  logic       s_ready;
  logic       m_valid;
  logic [1:0] m_data;
  logic       m_last;
  logic       m_ready = 1'b1;
  logic       len_err;

  int         vectors = 0;
  int         miscompares = 0;
  bit         go = 1'b0;
  logic [2:0] cap[$];
  int         le_cnt = 0;

  // Reference model state
  logic [2:0] q[$];
  bit         hist[$];
  ph_t        ph = PH_OPEN;
  int         cnt = 0;
  int         tails_left = 0;
  int         gap_left = 0;
  bit         exp_le = 1'b0;

  always #5 clk = ~clk;

  conv_encoder_framer #(
    .K          (K),
    .G0         (G0),
    .G1         (G1),
    .MAX_LEN    (MAX_LEN),
    .GAP_CYCLES (GAP_CYCLES)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .s_valid (s_valid),
    .s_data  (s_data),
    .s_last  (s_last),
    .s_ready (s_ready),
    .m_valid (m_valid),
    .m_data  (m_data),
    .m_last  (m_last),
    .m_ready (m_ready),
    .len_err (len_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Symbol for the newest bit of u: convolution of the frame history with the generators
  function automatic logic [1:0] enc(input bit u[$]);
    logic c0;
    logic c1;
    int   n;
    c0 = 1'b0;
    c1 = 1'b0;
    n  = u.size();
    for (int j = 0; j < int'(K); j++) begin
      if (n - 1 - j >= 0) begin
        c0 = c0 ^ (G0[K-1-j] & u[n-1-j]);
        c1 = c1 ^ (G1[K-1-j] & u[n-1-j]);
      end
    end
    return {c1, c0};
  endfunction

  task automatic model_reset();
    q.delete();
    hist.delete();
    ph         = PH_OPEN;
    cnt        = 0;
    tails_left = 0;
    gap_left   = 0;
    exp_le     = 1'b0;
  endtask

  // Compare process: check outputs every cycle, then advance the model over the coming edge
  initial begin : compare
    bit adv;
    bit exp_ready;
    logic [2:0] sy;
    wait (go);
    forever begin
      @(negedge clk);
      #1;
      chk("m_valid", 32'(m_valid), 32'(q.size() != 0));
      if (q.size() != 0) begin
        chk("m_data", 32'(m_data), 32'(q[0][1:0]));
        chk("m_last", 32'(m_last), 32'(q[0][2]));
      end else begin
        chk("m_last_idle", 32'(m_last), 32'd0);
      end
      chk("len_err", 32'(len_err), 32'(exp_le));
      if (len_err === 1'b1) le_cnt++;
      adv       = (q.size() == 0) || (m_ready === 1'b1);
      exp_ready = adv && (ph == PH_OPEN);
      chk("s_ready", 32'(s_ready), 32'(exp_ready));
      exp_le = 1'b0;
      if (rst) begin
        model_reset();
        continue;
      end
      if ((q.size() != 0) && m_ready) begin
        cap.push_back({m_last, m_data});
        sy = q.pop_front();
        if (sy[2]) begin
          ph       = PH_GAP;
          gap_left = GAP_CYCLES;
          hist.delete();
          cnt = 0;
        end
      end else if (ph == PH_GAP) begin
        gap_left--;
        if (gap_left == 0) ph = PH_OPEN;
      end
      if (exp_ready && s_valid) begin
        hist.push_back(s_data);
        cnt++;
        q.push_back({1'b0, enc(hist)});
        if (s_last || (cnt == int'(MAX_LEN))) begin
          ph         = PH_CLOSING;
          tails_left = K - 1;
          exp_le     = !s_last;
        end
      end else if ((ph == PH_CLOSING) && adv && (tails_left > 0)) begin
        hist.push_back(1'b0);
        tails_left--;
        q.push_back({tails_left == 0, enc(hist)});
      end
    end
  end

  // Offer n bits (LSB first), retrying each until accepted, with random ready/bubbles
  task automatic run_frame(input logic [15:0] bits, input int n, input bit with_last,
                           input int mr_pct, input int sv_pct);
    int i;
    int cyc;
    i   = 0;
    cyc = 0;
    while ((i < n) && (cyc < 400)) begin
      @(negedge clk);
      m_ready = (int'($urandom_range(0, 99)) < mr_pct);
      s_valid = (int'($urandom_range(0, 99)) < sv_pct);
      if (s_valid) begin
        s_data = bits[i];
        s_last = with_last && (i == n - 1);
      end else begin
        s_data = 1'($urandom_range(0, 1));
        s_last = 1'($urandom_range(0, 1));
      end
      #1;
      if (s_valid && s_ready) i++;
      cyc++;
    end
    chk("frame_accept_timeout", 32'(i), 32'(n));
  endtask

  task automatic idle(input int n, input int mr_pct);
    repeat (n) begin
      @(negedge clk);
      s_valid = 1'b0;
      s_data  = 1'($urandom_range(0, 1));
      s_last  = 1'($urandom_range(0, 1));
      m_ready = (int'($urandom_range(0, 99)) < mr_pct);
    end
  endtask

  initial begin : driver
    logic [2:0] exp1 [4];
    int         le0;
    exp1[0] = 3'b011;
    exp1[1] = 3'b011;
    exp1[2] = 3'b001;
    exp1[3] = 3'b111;

    rst     = 1'b1;
    m_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_m_valid", 32'(m_valid), 32'd0);
    chk("reset_m_data",  32'(m_data),  32'd0);
    chk("reset_m_last",  32'(m_last),  32'd0);
    chk("reset_len_err", 32'(len_err), 32'd0);
    chk("reset_s_ready", 32'(s_ready), 32'd1);
    rst = 1'b0;
    go  = 1'b1;

    // Single-bit frame: 11, 11, 01, 11 with m_last on the 4th
    cap.delete();
    run_frame(16'h0001, 1, 1'b1, 100, 100);
    idle(10, 100);
    chk("one_bit_count", 32'(cap.size()), 32'd4);
    for (int i = 0; i < 4 && i < cap.size(); i++) chk("one_bit_sym", 32'(cap[i]), 32'(exp1[i]));

    // Eight zero bits: eleven 00 symbols, m_last on the eleventh
    cap.delete();
    run_frame(16'h0000, 8, 1'b1, 100, 100);
    idle(20, 100);
    chk("zero_frame_count", 32'(cap.size()), 32'd11);
    for (int i = 0; i < 11 && i < cap.size(); i++)
      chk("zero_frame_sym", 32'(cap[i]), 32'({(i == 10), 2'b00}));

    // Backpressure held during the tail
    cap.delete();
    run_frame(16'h000B, 4, 1'b1, 100, 100);
    @(negedge clk);
    s_valid = 1'b0;
    m_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      m_ready = 1'b0;
    end
    idle(15, 100);
    chk("backpressure_count", 32'(cap.size()), 32'd7);

    // Forced termination at MAX_LEN; 9th bit waits out tail and gap
    le0 = le_cnt;
    run_frame(16'($urandom), 9, 1'b0, 100, 100);
    run_frame(16'h0001, 1, 1'b1, 100, 100);
    idle(15, 100);
    chk("len_err_pulses", 32'(le_cnt - le0), 32'd1);

    // Reset during the second tail symbol, then a clean frame from state zero
    run_frame(16'h0001, 1, 1'b1, 100, 100);
    @(negedge clk);
    s_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midreset_m_valid", 32'(m_valid), 32'd0);
    chk("midreset_m_last",  32'(m_last),  32'd0);
    chk("midreset_s_ready", 32'(s_ready), 32'd1);
    cap.delete();
    run_frame(16'h0001, 1, 1'b1, 100, 100);
    idle(10, 100);
    chk("after_reset_count", 32'(cap.size()), 32'd4);
    for (int i = 0; i < 4 && i < cap.size(); i++) chk("after_reset_sym", 32'(cap[i]), 32'(exp1[i]));

    // Random frames with bubbles, backpressure and over-length frames
    repeat (40) begin
      run_frame(16'($urandom), int'($urandom_range(1, 11)), ($urandom_range(0, 3) != 0),
                int'($urandom_range(40, 100)), int'($urandom_range(60, 100)));
      if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(0, 6)), int'($urandom_range(30, 100)));
    end
    run_frame(16'h0000, 1, 1'b1, 100, 100);
    idle(20, 100);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/conv_encoder_framer.md
Name: conv_encoder_framer

Overview:
Rate-1/2, constraint-length-4 convolutional encoder that produces the 2-bit symbol stream consumed by the Viterbi decoder's d_in/enable inputs. It accepts a framed serial bit stream and encodes each frame from the all-zero state. Each frame ends with K-1 zero tail bits, so the trellis terminates in state 000. Between frames it inserts an idle gap, during which the decoder's enable is deasserted and its path metrics are cleared.

Parameters:
K, 4, constraint length; shift register holds K-1 = 3 previous bits
G0, 4'b1111, generator for m_data[0]; bit K-1 taps the current input, bits K-2..0 tap sr[K-2..0]
G1, 4'b1101, generator for m_data[1]; same tap ordering as G0
MAX_LEN, 1024, maximum number of payload bits per frame
GAP_CYCLES, 4, number of idle cycles with m_valid=0 after each frame's final tail symbol

Ports:
clk  in  1  clock; all logic on posedge
rst  in  1  synchronous, active-high reset
s_valid  in  1  payload bit valid
s_data  in  1  payload bit
s_last  in  1  marks the final payload bit of the frame
s_ready  out  1  encoder accepts s_data this cycle
m_valid  out  1  symbol valid; drives decoder enable
m_data  out  2  encoded symbol {c1,c0}
m_last  out  1  marks the final tail symbol of the frame
m_ready  in  1  downstream accepts symbol; tie to 1 for the decoder
len_err  out  1  one-cycle pulse on forced termination at MAX_LEN

Behaviour:
- Reset is synchronous and active-high (rst=1 at posedge).
  - Reset values: state=IDLE, sr=0, bit_cnt=0, tail_cnt=0, gap_cnt=0.
  - Output reset values: m_valid=0, m_data=2'b00, m_last=0, len_err=0.
  - Reset mid-frame discards the frame immediately; no tail is emitted.
- Output register: a single stage holding m_valid/m_data/m_last.
  - The stage loads when adv = !m_valid || m_ready.
  - While m_valid=1 and m_ready=0, m_data and m_last hold stable.
- s_ready = adv && (state==IDLE || state==DATA). This is combinational in m_ready.
- Encode:
  - w = {in_bit, sr}; c0 = ^(w & G0); c1 = ^(w & G1); m_data <= {c1,c0}.
  - sr <= {in_bit, sr[K-2:1]}, so sr[K-2] is the most recent bit.
  - Latency: symbol appears on m_valid one cycle after the accepting edge.
- States:
  - IDLE: sr=0, bit_cnt=0. On accept (s_valid && s_ready), encode the bit and go to DATA; if s_last, go to TAIL instead.
  - DATA: on accept, encode and increment bit_cnt. Go to TAIL when s_last is set, or when the accepted bit is the MAX_LEN-th.
    - MAX_LEN-th bit without s_last: pulse len_err for one cycle.
    - MAX_LEN-th bit with s_last: no error.
  - TAIL: s_ready=0. On each adv, encode in_bit=0. Repeat K-1 times using tail_cnt.
    - The third tail symbol carries m_last=1.
    - After the third, sr=0; go to GAP.
  - GAP: s_ready=0. Once the last symbol is accepted (adv), the output register drops m_valid=0.
    - Count GAP_CYCLES cycles, then go to IDLE.
    - If GAP_CYCLES=0, go directly to IDLE once the last symbol is accepted.
- bit_cnt width: $clog2(MAX_LEN+1). It does not wrap, because termination at MAX_LEN is forced.
- s_data, s_last and s_valid are ignored whenever s_ready=0.
- A bubble in DATA (s_valid=0) produces no symbol; m_valid drops, with no stuffing.
  - Note: the decoder treats m_valid=0 as a restart, so sources must stream without bubbles.

Decomposition:
- Package conv_pkg holds:
  - K, G0, G1 defaults
  - typedef sym_t (logic [1:0])
  - enum state_t {IDLE, DATA, TAIL, GAP}
- Sub-module conv_enc_core: combinational/registered shift register plus parity (in_bit, load, clr -> sym).
- The framer FSM, counters and output register stay in the top level.

Test Plan:
- Single-bit frame, defaults: s_data=1 with s_last=1, m_ready=1 -> m_data sequence 11, 11, 01, 11 on consecutive cycles; m_last only on the 4th symbol; then 4 cycles of m_valid=0 before s_ready reasserts.
- 8-bit all-zero frame -> 11 symbols, all 00; m_last on the 11th symbol; sr=0 at the end.
- Backpressure: during the tail, hold m_ready=0 for 3 cycles -> m_data and m_last stay stable; no symbol is lost or duplicated; s_ready stays 0.
- MAX_LEN=8 with 9 bits offered and no s_last -> 8 bits accepted; len_err pulses once on the 8th accept; 3 tail symbols follow; the 9th bit is accepted only after the gap.
- Loopback: 1024 random bits through the Viterbi decoder with m_ready=1 -> decoded stream matches the input after the decoder's latency.
- Reset asserted during the 2nd tail symbol -> next cycle m_valid=0, m_last=0, state IDLE, s_ready=1; a new frame encodes from sr=0.
